// File: rtl/sdm_pkg.sv
// Shared types for the sigma-delta oversampling scheduler.
//   sched_state_t : scheduler FSM states
//   sample_t      : signed 16-bit PCM sample
package sdm_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sdm_osr_sched_if.sv
// Stream, modulator and decimator signals of the oversampling scheduler.
//   master : scheduler side (drives s_ready, dac_*, adc_valid, m_*, status)
//   slave  : environment side (drives enable, s_valid/s_data, adc_out_*)
interface sdm_osr_sched_if;
  import sdm_pkg::*;

  logic        enable;
  logic        s_valid;
  logic        s_ready;
  sample_t     s_data;
  logic        dac_valid;
  sample_t     dac_data;
  logic        adc_valid;
  logic        adc_out_valid;
  sample_t     adc_out_data;
  logic        m_valid;
  sample_t     m_data;
  logic        underrun;
  logic        busy;
  logic [15:0] underrun_cnt;

  modport master (
    input  enable, s_valid, s_data, adc_out_valid, adc_out_data,
    output s_ready, dac_valid, dac_data, adc_valid, m_valid, m_data,
           underrun, busy, underrun_cnt
  );

  modport slave (
    output enable, s_valid, s_data, adc_out_valid, adc_out_data,
    input  s_ready, dac_valid, dac_data, adc_valid, m_valid, m_data,
           underrun, busy, underrun_cnt
  );

endinterface

// File: rtl/sdm_sample_fifo.sv
// Synchronous sample FIFO with show-ahead read data and no fall-through.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request / data (ignored when full)
//   pop, dout  : read request (ignored when empty) / head-of-queue data
//   full, empty: occupancy flags
module sdm_sample_fifo
  import sdm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  sample_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_wr_en;
  logic          w_rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = push && !full;
  assign w_rd_en = pop && !empty;
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdm_osr_sched.sv
// Oversampling scheduler: buffers PCM samples, holds each on the DAC input
// for OSR modulator ticks, generates DAC/ADC tick strobes every CLK_DIV
// clocks and decimates the ADC stream to one sample per OSR valid pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sdm_osr_sched_if.master (stream in, DAC/ADC strobes,
//                decimated output, underrun/busy/underrun_cnt status)
// Optional: define SDM_SCHED_STATS_EN for a saturating underrun counter;
// otherwise underrun_cnt is tied to zero.
module sdm_osr_sched
  import sdm_pkg::*;
#(
  parameter int unsigned OSR        = 64,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  sdm_osr_sched_if.master bus
);

  localparam int unsigned TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FRAME_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_PRE   = TICK_W'(CLK_DIV - 2);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(OSR - 1);

  sched_state_t       r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [FRAME_W-1:0] r_dec_cnt;
  logic               r_tick;
  logic               r_underrun;
  logic               r_busy;
  logic               r_m_valid;
  sample_t            r_hold;
  sample_t            r_m_data;

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  logic    w_running;
  logic    w_frame_end;
  logic    w_underrun_set;
  logic    w_to_idle;
  sample_t w_fifo_dout;

  assign w_running      = (r_state == RUN) || (r_state == STOP);
  assign w_frame_end    = r_tick && (r_frame_cnt == FRAME_LAST);
  assign w_push         = bus.s_valid && !w_full;
  assign w_pop          = !w_empty &&
                          (((r_state == PRIME) && bus.enable) ||
                           ((r_state == RUN) && w_frame_end));
  assign w_underrun_set = (r_state == RUN) && w_frame_end && w_empty;
  assign w_to_idle      = ((r_state == PRIME) && !bus.enable) ||
                          ((r_state == STOP) && w_frame_end);

  sdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.s_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Scheduler FSM with tick/frame counters and the DAC hold register.
  // r_tick is set one cycle early so it is high exactly when
  // r_tick_cnt == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_frame_cnt <= '0;
      r_tick      <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_underrun <= 1'b0;
      if (w_running) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        r_tick     <= (r_tick_cnt == TICK_PRE);
        if (r_tick) begin
          r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
      end
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= PRIME;
            r_busy  <= 1'b1;
          end
        end
        PRIME: begin
          if (!bus.enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!w_empty) begin
            r_hold      <= w_fifo_dout;
            r_tick_cnt  <= '0;
            r_tick      <= 1'b0;
            r_frame_cnt <= '0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_frame_end) begin
            if (!w_empty) begin
              r_hold <= w_fifo_dout;
            end else begin
              r_hold     <= '0;
              r_underrun <= 1'b1;
            end
          end
          if (!bus.enable) r_state <= STOP;
        end
        STOP: begin
          if (w_frame_end) begin
            r_hold  <= '0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Decimator: forward every OSR-th ADC sample; restarts whenever IDLE is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_m_valid <= 1'b0;
      if ((r_state != IDLE) && bus.adc_out_valid) begin
        if (r_dec_cnt == FRAME_LAST) begin
          r_dec_cnt <= '0;
          r_m_valid <= 1'b1;
          r_m_data  <= bus.adc_out_data;
        end else begin
          r_dec_cnt <= r_dec_cnt + 1'b1;
        end
      end
      if (w_to_idle) r_dec_cnt <= '0;
    end
  end

`ifdef SDM_SCHED_STATS_EN
  logic [15:0] r_underrun_cnt;

  // Saturating underrun statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_set && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign bus.underrun_cnt = r_underrun_cnt;
`else
  assign bus.underrun_cnt = 16'h0000;
`endif

  assign bus.s_ready   = !w_full;
  assign bus.dac_valid = r_tick;
  assign bus.adc_valid = r_tick;
  assign bus.dac_data  = r_hold;
  assign bus.underrun  = r_underrun;
  assign bus.busy      = r_busy;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;

endmodule

// File: tb/tb_sdm_osr_sched.sv
// Self-checking bench for sdm_osr_sched (OSR=4, CLK_DIV=2, FIFO_DEPTH=4).
// Expected behaviour comes from a cycle-count model: ticks fall on every
// CLK_DIV-th cycle after the first pop, frames span OSR*CLK_DIV cycles, and
// the FIFO is a queue.
module tb_sdm_osr_sched;
  import sdm_pkg::*;

  localparam int unsigned OSR   = 4;
  localparam int unsigned CDIV  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned F     = OSR * CDIV;

`ifdef SDM_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdm_osr_sched_if bus ();

  sdm_osr_sched #(
    .OSR        (OSR),
    .CLK_DIV    (CDIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  sample_t q[$];
  sample_t m_hold;
  int      m_ucnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.enable        = 1'b0;
    bus.s_valid       = 1'b0;
    bus.s_data        = '0;
    bus.adc_out_valid = 1'b0;
    bus.adc_out_data  = '0;
    repeat (3) tick();
    q.delete();
    m_hold = '0;
    m_ucnt = 0;
    chk("rst_dac_valid", 32'(bus.dac_valid), 32'(0));
    chk("rst_adc_valid", 32'(bus.adc_valid), 32'(0));
    chk("rst_dac_data", 32'(bus.dac_data), 32'(0));
    chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
    chk("rst_underrun", 32'(bus.underrun), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
    chk("rst_underrun_cnt", 32'(bus.underrun_cnt), 32'(0));
    rst_n = 1'b1;
  endtask

  task automatic push_idle(input sample_t d);
    chk("push_s_ready", 32'(bus.s_ready), 32'(q.size() < DEPTH));
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    if (q.size() < DEPTH) q.push_back(d);
    tick();
    bus.s_valid = 1'b0;
    chk("push_s_ready_after", 32'(bus.s_ready), 32'(q.size() < DEPTH));
  endtask

  // One enable session from IDLE (FIFO non-empty) back to IDLE.
  // stop_c is the cycle (counted from the first pop, which is cycle 0) at
  // whose end enable is sampled low.
  task automatic run_session(input int stop_c, input bit rnd_push);
    int      stop_end;
    bit      in_run;
    bit      exp_und;
    bit      acc;
    bit      reasserted;
    stop_end   = ((stop_c + int'(F)) / int'(F)) * int'(F);
    reasserted = 1'b0;
    bus.enable = 1'b1;
    tick();
    chk("sess_prime_busy", 32'(bus.busy), 32'(1));
    tick();
    m_hold  = q.pop_front();
    exp_und = 1'b0;
    for (int c = 1; c <= stop_end + 1; c++) begin
      in_run = (c <= stop_end);
      chk("sess_busy", 32'(bus.busy), 32'(in_run));
      chk("sess_dac_valid", 32'(bus.dac_valid), 32'(in_run && (c % int'(CDIV) == 0)));
      chk("sess_adc_valid", 32'(bus.adc_valid), 32'(in_run && (c % int'(CDIV) == 0)));
      chk("sess_dac_data", 32'(bus.dac_data), 32'(m_hold));
      chk("sess_underrun", 32'(bus.underrun), 32'(exp_und));
      chk("sess_s_ready", 32'(bus.s_ready), 32'(q.size() < DEPTH));
      chk("sess_underrun_cnt", 32'(bus.underrun_cnt), 32'(m_ucnt));
      chk("sess_m_valid", 32'(bus.m_valid), 32'(0));
      if (c == stop_end + 1) break;
      if (c == stop_c) bus.enable = 1'b0;
      if ((c == stop_c + 1) && (stop_c + 2 < stop_end)) begin
        bus.enable = 1'b1;
        reasserted = 1'b1;
      end
      if ((c == stop_c + 2) && reasserted) bus.enable = 1'b0;
      bus.s_valid = rnd_push && ($urandom_range(0, 3) == 0);
      bus.s_data  = sample_t'($urandom);
      acc     = bus.s_valid && (q.size() < DEPTH);
      exp_und = 1'b0;
      if (c % int'(F) == 0) begin
        if (c == stop_end) begin
          m_hold = '0;
        end else if (q.size() > 0) begin
          m_hold = q.pop_front();
        end else begin
          m_hold  = '0;
          exp_und = 1'b1;
          if (STATS) m_ucnt++;
        end
      end
      if (acc) q.push_back(bus.s_data);
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    int      dcnt;
    int      gaps;
    bit      exp_mv;
    sample_t d;

    do_reset();

    // Enable with an empty FIFO: parks in PRIME, no ticks.
    bus.enable = 1'b1;
    tick();
    chk("prime_busy", 32'(bus.busy), 32'(1));
    repeat (5) begin
      tick();
      chk("prime_no_tick", 32'(bus.dac_valid), 32'(0));
      chk("prime_dac_data", 32'(bus.dac_data), 32'(0));
    end

    // Decimator while in PRIME: data 1..8 then two extra pulses.
    dcnt = 0;
    for (int i = 1; i <= 10; i++) begin
      gaps = int'($urandom_range(0, 2));
      repeat (gaps) begin
        tick();
        chk("dec_gap_m_valid", 32'(bus.m_valid), 32'(0));
      end
      d = (i <= 8) ? sample_t'(i) : sample_t'($urandom);
      bus.adc_out_valid = 1'b1;
      bus.adc_out_data  = d;
      tick();
      bus.adc_out_valid = 1'b0;
      exp_mv = ((dcnt % int'(OSR)) == int'(OSR) - 1);
      chk("dec_m_valid", 32'(bus.m_valid), 32'(exp_mv));
      if (exp_mv) chk("dec_m_data", 32'(bus.m_data), 32'(d));
      dcnt++;
    end
    tick();
    chk("dec_pulse_width", 32'(bus.m_valid), 32'(0));

    // Back to IDLE clears the decimator; IDLE pulses are ignored.
    bus.enable = 1'b0;
    tick();
    chk("prime_to_idle_busy", 32'(bus.busy), 32'(0));
    repeat (3) begin
      bus.adc_out_valid = 1'b1;
      bus.adc_out_data  = sample_t'($urandom);
      tick();
      chk("dec_idle_ignored", 32'(bus.m_valid), 32'(0));
    end
    bus.adc_out_valid = 1'b0;
    bus.enable = 1'b1;
    tick();
    for (int i = 0; i < int'(OSR); i++) begin
      d = sample_t'($urandom);
      bus.adc_out_valid = 1'b1;
      bus.adc_out_data  = d;
      tick();
      chk("dec_restart_m_valid", 32'(bus.m_valid), 32'(i == int'(OSR) - 1));
      if (i == int'(OSR) - 1) chk("dec_restart_m_data", 32'(bus.m_data), 32'(d));
    end
    bus.adc_out_valid = 1'b0;
    bus.enable = 1'b0;
    tick();
    chk("idle_again_busy", 32'(bus.busy), 32'(0));

    // 100, 200 then underrun, stop in the third frame.
    push_idle(sample_t'(100));
    push_idle(sample_t'(200));
    run_session(2 * int'(F) + 3, 1'b0);

    // Fill FIFO, reject a fifth sample, stop at tick 1 of frame 1.
    for (int i = 0; i < 5; i++) push_idle(sample_t'($urandom));
    run_session(int'(F) + int'(CDIV), 1'b0);

    // Replay what was left, then random sessions with concurrent pushes.
    run_session(int'($urandom_range(1, 4 * F)), 1'b1);
    repeat (3) begin
      if (q.size() == 0) push_idle(sample_t'($urandom));
      repeat ($urandom_range(0, 3)) push_idle(sample_t'($urandom));
      run_session(int'($urandom_range(1, 4 * F)), 1'b1);
    end

    // Three underrun frames, enable dropped exactly on a frame-end tick.
    do_reset();
    push_idle(sample_t'(-1234));
    run_session(3 * int'(F), 1'b0);
    chk("stats_after_frames", 32'(bus.underrun_cnt), 32'(STATS ? 3 : 0));
    do_reset();
    chk("stats_after_reset", 32'(bus.underrun_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
